// File: rtl/nes_alu_pkg.sv
// ============================================================================
// nes_alu_pkg : shared state encoding and byte width for the byte-serial ALU
// Revision    : 1.0
// ============================================================================
`default_nettype none

package nes_alu_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin arbiter with a last-served register
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic clk,
   input  logic reset_n,
   input  logic req0,
   input  logic req1,
   input  logic take,
   output logic grant
);

   logic last;

   // Under contention the requester that was not served last wins.
   always_comb begin
      grant = 1'b0;
      if (req0 && req1) begin
         grant = ~last;
      end else if (req1) begin
         grant = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last <= 1'b1;
      end else if (take) begin
         last <= grant;
      end
   end

endmodule

`default_nettype wire

// File: rtl/addsub_seq_arbiter.sv
// ============================================================================
// addsub_seq_arbiter : two requesters share one external 8-bit add/sub unit,
//                      multi-byte operations are run one byte per ce-cycle
// Revision           : 1.0
// ============================================================================
`default_nettype none

module addsub_seq_arbiter
   import nes_alu_pkg::*;
#(
   parameter int NBYTES = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       ce,

   input  logic                       req0_valid,
   output logic                       req0_ready,
   input  logic [8*NBYTES-1:0]        req0_a,
   input  logic [8*NBYTES-1:0]        req0_b,
   input  logic                       req0_add,
   input  logic                       req0_ci,

   input  logic                       req1_valid,
   output logic                       req1_ready,
   input  logic [8*NBYTES-1:0]        req1_a,
   input  logic [8*NBYTES-1:0]        req1_b,
   input  logic                       req1_add,
   input  logic                       req1_ci,

   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_id,
   output logic [8*NBYTES-1:0]        rsp_s,
   output logic                       rsp_co,
   output logic                       rsp_ofl,

   output logic [7:0]                 au_a,
   output logic [7:0]                 au_b,
   output logic                       au_ci,
   output logic                       au_add,
   input  logic [7:0]                 au_s,
   input  logic                       au_co,
   input  logic                       au_ofl
);

   localparam int                IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

   state_t                              state;
   state_t                              state_next;

   logic [NBYTES-1:0][BYTE_W-1:0]       op_a;
   logic [NBYTES-1:0][BYTE_W-1:0]       op_b;
   logic [NBYTES-1:0][BYTE_W-1:0]       res;
   logic                                op_add;
   logic                                carry;
   logic [IDX_W-1:0]                    idx;

   logic                                grant;
   logic                                accept;
   logic                                last_byte;
   logic [8*NBYTES-1:0]                 sel_a;
   logic [8*NBYTES-1:0]                 sel_b;
   logic                                sel_add;
   logic                                sel_ci;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req0    (req0_valid),
      .req1    (req1_valid),
      .take    (accept),
      .grant   (grant)
   );

   // Ready is also masked by reset so nothing is offered while held in reset.
   assign req0_ready = reset_n && ce && (state == IDLE) && req0_valid && !grant;
   assign req1_ready = reset_n && ce && (state == IDLE) && req1_valid &&  grant;
   assign accept     = req0_ready || req1_ready;

   assign sel_a      = grant ? req1_a   : req0_a;
   assign sel_b      = grant ? req1_b   : req0_b;
   assign sel_add    = grant ? req1_add : req0_add;
   assign sel_ci     = grant ? req1_ci  : req0_ci;

   assign last_byte  = (idx == LAST_IDX);
   assign rsp_valid  = (state == DONE);
   assign rsp_s      = res;

   always_comb begin
      au_a   = 8'h00;
      au_b   = 8'h00;
      au_ci  = 1'b0;
      au_add = 1'b1;
      if (state == RUN) begin
         au_a   = op_a[idx];
         au_b   = op_b[idx];
         au_ci  = carry;
         au_add = op_add;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (ce) begin
         case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_byte) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
         endcase
      end
   end

   // Byte-serial datapath: the carry register chains bytes through the shared unit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_a    <= '0;
         op_b    <= '0;
         op_add  <= 1'b1;
         carry   <= 1'b0;
         idx     <= '0;
         res     <= '0;
         rsp_id  <= 1'b0;
         rsp_co  <= 1'b0;
         rsp_ofl <= 1'b0;
      end else if (ce) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_a   <= sel_a;
                  op_b   <= sel_b;
                  op_add <= sel_add;
                  carry  <= sel_ci;
                  rsp_id <= grant;
                  idx    <= '0;
               end
            end
            RUN: begin
               res[idx] <= au_s;
               carry    <= au_co;
               idx      <= idx + IDX_W'(1);
               if (last_byte) begin
                  rsp_co  <= au_co;
                  rsp_ofl <= au_ofl;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_addsub_seq_arbiter.sv
// ============================================================================
// tb_addsub_seq_arbiter : scoreboard bench with external 8-bit add/sub unit
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_addsub_seq_arbiter;

   localparam int NB = 2;
   localparam int W  = 8 * NB;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         add;
      logic         ci;
      logic         has_exp;
      logic [W-1:0] es;
      logic         eco;
      logic         eofl;
   } txn_t;

   typedef struct packed {
      logic         id;
      logic [W-1:0] s;
      logic         co;
      logic         ofl;
      int unsigned  acc_ce;
   } exp_t;

   logic         clk;
   logic         reset_n;
   logic         ce;
   logic         req0_valid, req0_ready, req0_add, req0_ci;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_add, req1_ci;
   logic [W-1:0] req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_co, rsp_ofl;
   logic [W-1:0] rsp_s;
   logic [7:0]   au_a, au_b, au_s;
   logic         au_ci, au_add, au_co, au_ofl;

   addsub_seq_arbiter #(.NBYTES(NB)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ce         (ce),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_add   (req0_add),
      .req0_ci    (req0_ci),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_add   (req1_add),
      .req1_ci    (req1_ci),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_s      (rsp_s),
      .rsp_co     (rsp_co),
      .rsp_ofl    (rsp_ofl),
      .au_a       (au_a),
      .au_b       (au_b),
      .au_ci      (au_ci),
      .au_add     (au_add),
      .au_s       (au_s),
      .au_co      (au_co),
      .au_ofl     (au_ofl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The integrator's 8-bit add/sub unit.
   always_comb begin
      logic [7:0] bb;
      logic [8:0] t;
      bb     = au_add ? au_b : ~au_b;
      t      = {1'b0, au_a} + {1'b0, bb} + {8'd0, au_ci};
      au_s   = t[7:0];
      au_co  = t[8];
      au_ofl = (au_a[7] == bb[7]) && (t[7] != au_a[7]);
   end

   txn_t        pend0[$];
   txn_t        pend1[$];
   exp_t        sb[$];
   int          grant_log[$];
   int unsigned acc_ce_log[$];
   int unsigned ret_ce_log[$];
   bit          acc0, acc1, busy, shown, last;
   int unsigned ce_cnt = 0;
   int          checks = 0;
   int          errors = 0;
   int          ce_mode, rdy_mode;
   logic [W-1:0] held_s;
   logic        held_id, held_co, held_ofl;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole-word reference: S = A + (add ? B : ~B) + ci.
   function automatic exp_t ref_calc(input txn_t t, input logic id);
      exp_t         e;
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb       = t.add ? t.b : ~t.b;
      full     = {1'b0, t.a} + {1'b0, bb} + {{W{1'b0}}, t.ci};
      e.id     = id;
      e.s      = full[W-1:0];
      e.co     = full[W];
      e.ofl    = (t.a[W-1] == bb[W-1]) && (full[W-1] != t.a[W-1]);
      e.acc_ce = 0;
      if (t.has_exp) begin
         e.s   = t.es;
         e.co  = t.eco;
         e.ofl = t.eofl;
      end
      return e;
   endfunction

   function automatic txn_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic add,
                               input logic ci, input logic has, input logic [W-1:0] es,
                               input logic eco, input logic eofl);
      txn_t t;
      t.a = a; t.b = b; t.add = add; t.ci = ci;
      t.has_exp = has; t.es = es; t.eco = eco; t.eofl = eofl;
      return t;
   endfunction

   function automatic txn_t rnd_txn();
      return mk(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, 1'b0, 1'b0);
   endfunction

   always @(posedge clk) begin
      if (reset_n && ce) ce_cnt <= ce_cnt + 1;
   end

   // Requester and environment drivers.
   always @(posedge clk) begin
      #1;
      if (acc0) begin void'(pend0.pop_front()); acc0 = 1'b0; end
      if (acc1) begin void'(pend1.pop_front()); acc1 = 1'b0; end
      if (pend0.size() > 0) begin
         req0_valid = 1'b1; req0_a = pend0[0].a; req0_b = pend0[0].b;
         req0_add = pend0[0].add; req0_ci = pend0[0].ci;
      end else begin
         req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom);
         req0_add = 1'($urandom); req0_ci = 1'($urandom);
      end
      if (pend1.size() > 0) begin
         req1_valid = 1'b1; req1_a = pend1[0].a; req1_b = pend1[0].b;
         req1_add = pend1[0].add; req1_ci = pend1[0].ci;
      end else begin
         req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom);
         req1_add = 1'($urandom); req1_ci = 1'($urandom);
      end
      case (ce_mode)
         0:       ce = 1'b1;
         1:       ce = ~ce;
         default: ce = ($urandom_range(0, 2) != 0);
      endcase
      rsp_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
   end

   // Monitor: arbitration model, acceptance capture and response scoreboard.
   always @(negedge clk) begin : mon
      logic e0, e1;
      exp_t e;
      if (reset_n) begin
         e0 = 1'b0;
         e1 = 1'b0;
         if (ce && !busy) begin
            if (req0_valid && req1_valid) begin
               e0 = last; e1 = !last;
            end else begin
               e0 = req0_valid; e1 = req1_valid;
            end
         end
         chk("ready", {req1_ready, req0_ready}, {e1, e0});
         if (!busy || rsp_valid)
            chk("au_idle", {au_a, au_b, au_ci, au_add}, {8'h00, 8'h00, 1'b0, 1'b1});

         if (req0_valid && req0_ready) begin
            e = ref_calc(pend0[0], 1'b0); e.acc_ce = ce_cnt;
            sb.push_back(e); last = 1'b0; busy = 1'b1; acc0 = 1'b1;
            grant_log.push_back(0); acc_ce_log.push_back(ce_cnt);
         end else if (req1_valid && req1_ready) begin
            e = ref_calc(pend1[0], 1'b1); e.acc_ce = ce_cnt;
            sb.push_back(e); last = 1'b1; busy = 1'b1; acc1 = 1'b1;
            grant_log.push_back(1); acc_ce_log.push_back(ce_cnt);
         end

         if (rsp_valid) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rsp: got id=%0d s=%0h expected none", rsp_id, rsp_s);
            end else if (!shown) begin
               chk("rsp_id",  rsp_id,  sb[0].id);
               chk("rsp_s",   rsp_s,   sb[0].s);
               chk("rsp_co",  rsp_co,  sb[0].co);
               chk("rsp_ofl", rsp_ofl, sb[0].ofl);
               chk("latency", 64'(ce_cnt - sb[0].acc_ce - 1), NB);
               held_s = rsp_s; held_id = rsp_id; held_co = rsp_co; held_ofl = rsp_ofl;
               shown = 1'b1;
            end else begin
               chk("rsp_hold", {rsp_id, rsp_s, rsp_co, rsp_ofl},
                   {held_id, held_s, held_co, held_ofl});
            end
            if (rsp_ready && ce) begin
               if (sb.size() > 0) void'(sb.pop_front());
               shown = 1'b0; busy = 1'b0;
               ret_ce_log.push_back(ce_cnt);
            end
         end
      end
   end

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0 || busy) && n < budget) begin
         @(negedge clk); #2; n++;
      end
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d cycles expected under %0d", n, budget);
      end
   endtask

   task automatic clear_model();
      sb.delete(); grant_log.delete(); acc_ce_log.delete(); ret_ce_log.delete();
      busy = 1'b0; shown = 1'b0; last = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; ce = 1'b1; rsp_ready = 1'b1; ce_mode = 0; rdy_mode = 0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_add = 1'b1; req0_ci = 1'b0;
      req1_a = '0; req1_b = '0; req1_add = 1'b1; req1_ci = 1'b0;
      clear_model();

      // Contention right out of reset: expect grants 0, 1, 0.
      pend0.push_back(rnd_txn()); pend0.push_back(rnd_txn()); pend1.push_back(rnd_txn());
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ready", {req1_ready, req0_ready}, 2'b00);
      chk("reset_rsp", {rsp_valid, rsp_id, rsp_s, rsp_co, rsp_ofl}, '0);
      chk("reset_au", {au_a, au_b, au_ci, au_add}, {8'h00, 8'h00, 1'b0, 1'b1});
      @(posedge clk); #3; reset_n = 1'b1;
      wait_drain(200);
      if (grant_log.size() == 3 && ret_ce_log.size() >= 2) begin
         chk("grant_order", {grant_log[0][0], grant_log[1][0], grant_log[2][0]}, 3'b010);
         chk("retire_gap1", acc_ce_log[1], ret_ce_log[0] + 1);
         chk("retire_gap2", acc_ce_log[2], ret_ce_log[1] + 1);
      end else begin
         checks++; errors++;
         $display("FAIL grant_count: got %0d expected 3", grant_log.size());
      end

      pend0.push_back(mk(16'h12FF, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h1300, 1'b0, 1'b0));
      wait_drain(100);
      pend1.push_back(mk(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0));
      wait_drain(100);
      pend0.push_back(mk(16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1));
      wait_drain(100);

      ce_mode = 1;
      pend0.push_back(mk(16'h12FF, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h1300, 1'b0, 1'b0));
      wait_drain(100);
      ce_mode = 0;

      // Reset while an operation is in RUN.
      pend1.push_back(mk(16'hA5C3, 16'h3C5A, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0));
      begin
         int n = 0;
         while (!(busy && !rsp_valid) && n < 50) begin @(negedge clk); #1; n++; end
         if (n >= 50) begin
            checks++; errors++;
            $display("FAIL run_wait: got %0d cycles expected under 50", n);
         end
      end
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_au_idle", {au_a, au_b, au_ci, au_add}, {8'h00, 8'h00, 1'b0, 1'b1});
      clear_model();
      pend0.delete(); pend1.delete();
      pend1.push_back(rnd_txn()); pend0.push_back(rnd_txn());
      repeat (2) begin
         @(negedge clk); #1;
         chk("rst_no_ready", {req1_ready, req0_ready}, 2'b00);
      end
      @(posedge clk); #3; reset_n = 1'b1;
      wait_drain(200);
      if (grant_log.size() > 0) chk("post_reset_grant", grant_log[0], 0);
      else begin
         checks++; errors++;
         $display("FAIL post_reset_grant: got none expected 0");
      end

      // Randomized traffic with random ce and back-pressure.
      ce_mode = 2; rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) pend0.push_back(rnd_txn());
         else                           pend1.push_back(rnd_txn());
      end
      wait_drain(4000);

      $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
